// File: rtl/nanorv32_ahbl_dmem_resp.sv
// AHB-Lite data-memory responder for the nanorv32 data bus: word RAM with
// byte lanes, programmable wait states, ERROR response and store-to-load forwarding.
module nanorv32_ahbl_dmem_resp #(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);
    localparam int         IW    = ADDR_WIDTH - 2;
    localparam int         DEPTH = 2 ** IW;
    localparam logic [2:0] WS    = 3'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic [IW-1:0] idx_q, a_idx;
    logic [3:0]    be_q, a_be;
    logic          wr_q;
    logic          a_legal, take, commit, fwd;
    logic [31:0]   rd_word;
    logic [31:0]   mem [DEPTH];
    logic          unused_bits;

    assign unused_bits = ^{haddr[31:ADDR_WIDTH], htrans[0]};

    assign a_idx  = haddr[ADDR_WIDTH-1:2];
    // Only IDLE/DONE/ERR2 can see hready high, so accepts are gated to those.
    assign take   = hsel & htrans[1] & hready & (state inside {IDLE, DONE, ERR2});
    assign commit = (state == DONE) & wr_q;
    assign fwd    = commit & (idx_q == a_idx);

    always_comb begin
        a_be    = 4'b0000;
        a_legal = 1'b1;
        case (hsize)
            3'd0: a_be = 4'b0001 << haddr[1:0];
            3'd1: begin
                a_be    = haddr[1] ? 4'b1100 : 4'b0011;
                a_legal = ~haddr[0];
            end
            3'd2: begin
                a_be    = 4'b1111;
                a_legal = (haddr[1:0] == 2'b00);
            end
            default: a_legal = 1'b0;
        endcase
    end

    // Read word with the lanes of a write committing on this same edge bypassed in.
    always_comb begin
        rd_word = mem[a_idx];
        for (int i = 0; i < 4; i++)
            if (fwd && be_q[i]) rd_word[8*i +: 8] = hwdata[8*i +: 8];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WAIT: begin
                if (cnt == 3'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 3'd1;
            end
            ERR1: state_nxt = ERR2;
            default: begin
                state_nxt = IDLE;
                if (take) begin
                    if (!a_legal)        state_nxt = ERR1;
                    else if (WS == 3'd0) state_nxt = DONE;
                    else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WS - 3'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            WAIT:    hreadyout = 1'b0;
            ERR1:    begin hreadyout = 1'b0; hresp = 1'b1; end
            ERR2:    hresp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            idx_q  <= '0;
            be_q   <= 4'b0000;
            wr_q   <= 1'b0;
            hrdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                idx_q <= a_idx;
                be_q  <= a_legal ? a_be : 4'b0000;
                wr_q  <= hwrite & a_legal;
                if (a_legal && !hwrite) hrdata <= rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit)
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
    end

endmodule

// File: tb/tb_nanorv32_ahbl_dmem_resp.sv
// Directed bench: one responder with zero wait states, one with three, sharing the bus.
module tb_nanorv32_ahbl_dmem_resp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic        dsel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'd0;
    logic        hready;
    logic [31:0] rd0, rd3, rdata;
    logic        ro0, ro3, rsp0, rsp3, resp;
    logic        hsel0, hsel3;

    int          n_chk = 0;
    int          n_fail = 0;
    int          waits;
    logic [31:0] rdata_done;

    always #5 clk = ~clk;

    assign hsel0  = hsel & ~dsel;
    assign hsel3  = hsel & dsel;
    assign hready = dsel ? ro3 : ro0;
    assign rdata  = dsel ? rd3 : rd0;
    assign resp   = dsel ? rsp3 : rsp0;

    nanorv32_ahbl_dmem_resp #(.ADDR_WIDTH(14), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata(rd0), .hreadyout(ro0), .hresp(rsp0));

    nanorv32_ahbl_dmem_resp #(.ADDR_WIDTH(14), .WAIT_STATES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata(rd3), .hreadyout(ro3), .hresp(rsp3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic w, input logic [2:0] sz, input logic [31:0] a);
        hsel = 1'b1; htrans = 2'b10; hwrite = w; hsize = sz; haddr = a;
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00;
    endtask

    // Single transfer: counts wait cycles and captures hrdata in the final data cycle.
    task automatic xfer(input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
        int n;
        drive_addr(w, sz, a);
        step();
        drive_idle();
        hwdata = wd;
        n = 0;
        while (!hready && n < 16) begin
            step();
            n++;
        end
        chk("xfer_bound", 32'(n < 16), 32'd1);
        waits      = n;
        rdata_done = rdata;
        step();
    endtask

    task automatic err_seq(input string tag, input logic w, input logic [2:0] sz,
                           input logic [31:0] a);
        drive_addr(w, sz, a);
        hwdata = 32'hFFFF_FFFF;
        step();
        drive_idle();
        chk({tag, "_err1_rdy"}, 32'(hready), 32'd0);
        chk({tag, "_err1_resp"}, 32'(resp), 32'd1);
        step();
        chk({tag, "_err2_rdy"}, 32'(hready), 32'd1);
        chk({tag, "_err2_resp"}, 32'(resp), 32'd1);
        step();
        chk({tag, "_idle_resp"}, 32'(resp), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_rdy_w0", 32'(ro0), 32'd1);
        chk("rst_resp_w0", 32'(rsp0), 32'd0);
        chk("rst_rdata_w0", rd0, 32'd0);
        chk("rst_rdy_w3", 32'(ro3), 32'd1);
        chk("rst_resp_w3", 32'(rsp3), 32'd0);
        chk("rst_rdata_w3", rd3, 32'd0);

        // zero-wait word write then read
        xfer(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        chk("wr_w0_waits", 32'(waits), 32'd0);
        xfer(1'b0, 3'd2, 32'h10, 32'd0);
        chk("rd_w0_waits", 32'(waits), 32'd0);
        chk("rd_w0_data", rdata_done, 32'hDEAD_BEEF);

        // sub-word merge; hrdata must hold across writes
        xfer(1'b1, 3'd2, 32'h20, 32'h1122_3344);
        xfer(1'b1, 3'd0, 32'h21, 32'h0000_AA00);
        xfer(1'b1, 3'd1, 32'h22, 32'h5566_0000);
        chk("rdata_hold_wr", rdata, 32'hDEAD_BEEF);
        xfer(1'b0, 3'd2, 32'h20, 32'd0);
        chk("merge_data", rdata, 32'h5566_AA44);

        // back-to-back write/read of the same word
        drive_addr(1'b1, 3'd2, 32'h30);
        step();
        hwdata = 32'hCAFE_F00D;
        drive_addr(1'b0, 3'd2, 32'h30);
        step();
        drive_idle();
        chk("fwd_word", rdata, 32'hCAFE_F00D);
        drive_addr(1'b1, 3'd1, 32'h32);
        step();
        hwdata = 32'h1234_0000;
        drive_addr(1'b0, 3'd2, 32'h30);
        step();
        drive_idle();
        chk("fwd_half", rdata, 32'h1234_F00D);
        step();
        xfer(1'b0, 3'd2, 32'h30, 32'd0);
        chk("fwd_half_ram", rdata, 32'h1234_F00D);

        // error responses leave RAM and hrdata alone
        xfer(1'b1, 3'd2, 32'h40, 32'h0102_0304);
        xfer(1'b0, 3'd2, 32'h40, 32'd0);
        chk("pre_err_data", rdata, 32'h0102_0304);
        err_seq("word42", 1'b1, 3'd2, 32'h42);
        err_seq("size3", 1'b1, 3'd3, 32'h40);
        err_seq("half41", 1'b0, 3'd1, 32'h41);
        chk("rdata_hold_err", rdata, 32'h0102_0304);
        xfer(1'b0, 3'd2, 32'h40, 32'd0);
        chk("ram_after_err", rdata, 32'h0102_0304);

        // legal read accepted during ERR2
        drive_addr(1'b1, 3'd1, 32'h41);
        step();
        chk("e2rd_err1_rdy", 32'(hready), 32'd0);
        drive_addr(1'b0, 3'd2, 32'h10);
        step();
        chk("e2rd_err2_resp", 32'(resp), 32'd1);
        step();
        drive_idle();
        chk("e2rd_done_rdy", 32'(hready), 32'd1);
        chk("e2rd_done_resp", 32'(resp), 32'd0);
        chk("e2rd_done_data", rdata, 32'hDEAD_BEEF);
        step();

        // three wait states
        dsel = 1'b1;
        xfer(1'b1, 3'd2, 32'h40, 32'h0BAD_C0DE);
        chk("wr_w3_waits", 32'(waits), 32'd3);
        xfer(1'b0, 3'd2, 32'h40, 32'd0);
        chk("rd_w3_waits", 32'(waits), 32'd3);
        chk("rd_w3_data", rdata_done, 32'h0BAD_C0DE);

        // reset in the second wait cycle of a write abandons it
        drive_addr(1'b1, 3'd2, 32'h40);
        step();
        drive_idle();
        hwdata = 32'h5555_5555;
        chk("abort_wait1_rdy", 32'(hready), 32'd0);
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_rst_rdy", 32'(hready), 32'd1);
        chk("abort_rst_resp", 32'(resp), 32'd0);
        chk("abort_rst_rdata", rdata, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("abort_idle_rdy", 32'(hready), 32'd1);
        xfer(1'b0, 3'd2, 32'h40, 32'd0);
        chk("abort_old_data", rdata, 32'h0BAD_C0DE);
        chk("abort_rd_waits", 32'(waits), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
